// File: rtl/uart_pkg.sv
// uart_pkg: shared UART baud default, receiver state encoding.
// Used by uart_rx and the existing transmitter.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int FIFO_DEPTH_DEF   = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: core-side load port of the receiver.
// Pop/clear requests in; head byte, valid and sticky flags out.
interface uart_rx_if;

  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rd_en,
    output err_clr,
    input  rd_data,
    input  valid,
    input  frame_err,
    input  overrun
  );

  modport slave (
    input  rd_en,
    input  err_clr,
    output rd_data,
    output valid,
    output frame_err,
    output overrun
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FWFT FIFO, dout reads 0 when empty.
// Ports: CLK, RSTN, push/din, pop/dout, empty, full.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             rd;
  logic             wr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // A full FIFO still accepts a write when the head leaves this cycle.
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);

  assign dout = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with synchronizer, FIFO and sticky errors.
// Ports: CLK, RSTN, rx line; bus (rd_en, err_clr, rd_data, valid, flags).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic     CLK,
  input  logic     RSTN,
  input  logic     rx,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic      rx_meta;
  logic      rxs;
  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          push;
  logic          ferr_set;
  logic          ovr_set;
  logic          empty;
  logic          full;
  logic          bit_end;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

  assign bit_end = (cnt == LAST);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shreg_n  = shreg;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n = '0;
          if (rxs) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            idx_n   = '0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n        = '0;
          shreg_n[idx] = rxs;
          if (idx == 3'd7) state_n = STOP;
          else idx_n = idx + 3'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (rxs) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A simultaneous pop frees the slot, so only a pop-less push overruns.
  assign ovr_set = push && full && !(bus.rd_en && !empty);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      if (ferr_set)         bus.frame_err <= 1'b1;
      else if (bus.err_clr) bus.frame_err <= 1'b0;
      if (ovr_set)          bus.overrun <= 1'b1;
      else if (bus.err_clr) bus.overrun <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK  (CLK),
    .RSTN (RSTN),
    .push (push),
    .din  (shreg),
    .pop  (bus.rd_en),
    .dout (bus.rd_data),
    .empty(empty),
    .full (full)
  );

  assign bus.valid = !empty;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit.
// Drives bit-accurate 8N1 frames and checks popped bytes and flags.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [7:0] q[$];
  int   lat;

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT(BIT),
    .FIFO_DEPTH  (4)
  ) dut (
    .CLK (clk),
    .RSTN(rstn),
    .rx  (rx),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b,
                      input logic stop_b,
                      input logic expect_b);
    if (expect_b) q.push_back(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_b);
    rx = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    int n;
    n = 0;
    while (!bus.valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.valid), 32'd1);
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk(tag, 32'(bus.rd_data), 32'(e));
    end
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_data", 32'(bus.rd_data), 32'd0);
    chk("rst_ferr", 32'(bus.frame_err), 32'd0);
    chk("rst_ovr", 32'(bus.overrun), 32'd0);
    rstn = 1'b1;
    idle(10);

    // Latency from the first edge seeing rx low to valid.
    fork
      send(8'hA5, 1'b1, 1'b1);
      begin
        lat = 0;
        while (lat < 400) begin
          @(posedge clk);
          lat++;
          #1;
          if (bus.valid) break;
        end
      end
    join
    chk("lat_a5", 32'(lat), 32'd155);
    chk("a5_ferr", 32'(bus.frame_err), 32'd0);
    chk("a5_ovr", 32'(bus.overrun), 32'd0);
    pop_check("a5");
    chk("a5_empty", 32'(bus.valid), 32'd0);
    idle(20);

    send(8'h00, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1);
    send(8'h5A, 1'b1, 1'b1);
    idle(4);
    pop_check("b2b_0");
    pop_check("b2b_1");
    pop_check("b2b_2");
    chk("b2b_empty", 32'(bus.valid), 32'd0);
    chk("b2b_zero", 32'(bus.rd_data), 32'd0);
    idle(20);

    for (int i = 1; i <= 5; i++)
      send(8'(i), 1'b1, i <= 4);
    idle(4);
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    chk("ovr_ferr", 32'(bus.frame_err), 32'd0);
    for (int i = 0; i < 4; i++) pop_check("ovr_pop");
    chk("ovr_empty", 32'(bus.valid), 32'd0);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("ovr_clr", 32'(bus.overrun), 32'd0);
    idle(20);

    send(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(20);
    chk("fe_set", 32'(bus.frame_err), 32'd1);
    chk("fe_valid", 32'(bus.valid), 32'd0);
    send(8'hC3, 1'b1, 1'b1);
    idle(4);
    pop_check("fe_next");
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("fe_clr", 32'(bus.frame_err), 32'd0);
    idle(20);

    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    chk("gl_valid", 32'(bus.valid), 32'd0);
    chk("gl_idle", 32'(dut.state), 32'(IDLE));
    send(8'h7E, 1'b1, 1'b1);
    idle(4);
    pop_check("gl_7e");
    idle(20);

    // Abort a frame during data bit 3 (bits 0..3 = 1,0,1,1).
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("mr_state", 32'(dut.state), 32'(IDLE));
    chk("mr_valid", 32'(bus.valid), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle(40);
    chk("mr_nopart", 32'(bus.valid), 32'd0);
    send(8'h81, 1'b1, 1'b1);
    idle(4);
    chk("mr_ferr", 32'(bus.frame_err), 32'd0);
    chk("mr_ovr", 32'(bus.overrun), 32'd0);
    pop_check("mr_81");
    chk("mr_empty", 32'(bus.valid), 32'd0);
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
